// File: rtl/quota_pkg.sv
// ============================================================================
//  Module : quota_pkg
//  Brief  : Shared types, defaults and quota arithmetic for quota_stream_gen.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package quota_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam int DEF_NCH       = 4;
    localparam int DEF_BITSTREAM = 64;
    localparam int DEF_QUANT     = 8;
    localparam int DEF_SPREAD    = 1;

    function automatic int shift_bip(input int quant, input int l);
        return quant - l;
    endfunction

    function automatic int shift_uni(input int quant, input int l);
        return quant - 1 - l;
    endfunction

    // Round-to-nearest rescale of a QUANT-bit code onto 0..2^l ones.
    function automatic int calc_quota(input int data, input logic unipol,
                                      input int quant, input int l);
        int u;
        int s;
        if (unipol) begin
            u = (data < 0) ? 0 : data;
            s = shift_uni(quant, l);
        end else begin
            u = data + (1 << (quant - 1));
            s = shift_bip(quant, l);
        end
        if (s == 0) begin
            return u;
        end
        return (u + (1 << (s - 1))) >> s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/quota_calc.sv
// ============================================================================
//  Module : quota_calc
//  Brief  : Combinational per-channel mapping of a signed code to a quota.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module quota_calc
    import quota_pkg::*;
#(
    parameter int BITSTREAM = DEF_BITSTREAM,
    parameter int QUANT     = DEF_QUANT
) (
    input  logic [QUANT-1:0]           data_i,
    input  logic                       unipol_i,
    output logic [$clog2(BITSTREAM):0] quota_o
);

    localparam int L  = $clog2(BITSTREAM);
    localparam int QW = L + 1;

    assign quota_o = QW'(calc_quota(int'($signed(data_i)), unipol_i, QUANT, L));

endmodule

`default_nettype wire

// File: rtl/quota_stream_gen.sv
// ============================================================================
//  Module : quota_stream_gen
//  Brief  : Multi-channel quota encoder and stochastic bitstream generator.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module quota_stream_gen
    import quota_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int BITSTREAM = DEF_BITSTREAM,
    parameter int QUANT     = DEF_QUANT,
    parameter int SPREAD    = DEF_SPREAD
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NCH*QUANT-1:0]                 in_data,
    input  logic                                 in_unipol,
    output logic [NCH*($clog2(BITSTREAM)+1)-1:0] quota_o,
    output logic                                 bs_valid,
    input  logic                                 bs_ready,
    output logic [NCH-1:0]                       bs_data,
    output logic                                 bs_last,
    output logic                                 busy
);

    localparam int             L         = $clog2(BITSTREAM);
    localparam int             QW        = L + 1;
    localparam logic [L-1:0]   LAST_BEAT = L'(BITSTREAM - 1);

    if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_bitstream
        $error("quota_stream_gen: BITSTREAM must be a power of 2");
    end
    if (QUANT < L + 1) begin : g_bad_quant
        $error("quota_stream_gen: QUANT must be at least log2(BITSTREAM)+1");
    end

    state_e                 state_q, state_d;
    logic [NCH*QUANT-1:0]   data_q;
    logic                   unipol_q;
    logic [NCH*QW-1:0]      quota_q;
    logic [NCH*QW-1:0]      acc_q, acc_d;
    logic [NCH*QW-1:0]      quota_d;
    logic [L-1:0]           beat_q;
    logic [NCH-1:0]         bit_raw;
    logic                   on_last;

    assign on_last = (beat_q == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        bs_valid = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = STREAM;
            end
            STREAM: begin
                bs_valid = 1'b1;
                if (bs_ready && on_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [QW-1:0] sum_c;

        quota_calc #(
            .BITSTREAM (BITSTREAM),
            .QUANT     (QUANT)
        ) u_calc (
            .data_i   (data_q[c*QUANT +: QUANT]),
            .unipol_i (unipol_q),
            .quota_o  (quota_d[c*QW +: QW])
        );

        // acc < BITSTREAM and quota <= BITSTREAM, so the sum fits in QW bits.
        assign sum_c               = acc_q[c*QW +: QW] + quota_q[c*QW +: QW];
        assign acc_d[c*QW +: QW]   = {1'b0, sum_c[L-1:0]};

        if (SPREAD != 0) begin : g_spread
            assign bit_raw[c] = sum_c[L];
        end else begin : g_thermo
            assign bit_raw[c] = ({1'b0, beat_q} < quota_q[c*QW +: QW]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            unipol_q <= 1'b0;
            quota_q  <= '0;
            acc_q    <= '0;
            beat_q   <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                data_q   <= in_data;
                unipol_q <= in_unipol;
            end
            if (state_q == LOAD) begin
                quota_q <= quota_d;
                acc_q   <= '0;
                beat_q  <= '0;
            end else if (state_q == STREAM && bs_ready) begin
                acc_q  <= acc_d;
                beat_q <= beat_q + L'(1);
            end
        end
    end

    assign quota_o = quota_q;
    assign bs_data = bs_valid ? bit_raw : '0;
    assign bs_last = bs_valid & on_last;

endmodule

`default_nettype wire

// File: tb/tb_quota_stream_gen.sv
// ============================================================================
//  Module : tb_quota_stream_gen
//  Brief  : Self-checking bench for quota_stream_gen (spread and thermometer).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_quota_stream_gen;

    localparam int NCH = 4;
    localparam int BS  = 8;
    localparam int QN  = 8;
    localparam int QW  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [NCH*QN-1:0] in_data = '0;
    logic              in_unipol = 1'b0;
    logic              bs_ready = 1'b0;

    logic              in_ready, bs_valid, bs_last, busy;
    logic [NCH*QW-1:0] quota_s;
    logic [NCH-1:0]    bs_data;
    logic              in_ready_t, bs_valid_t, bs_last_t, busy_t;
    logic [NCH*QW-1:0] quota_t;
    logic [NCH-1:0]    bs_data_t;

    int checks = 0;
    int errors = 0;
    int din [NCH];
    int eq  [NCH];
    logic [BS-1:0] cap_sp, cap_th;

    always #5 clk = ~clk;

    quota_stream_gen #(.NCH(NCH), .BITSTREAM(BS), .QUANT(QN), .SPREAD(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_unipol(in_unipol), .quota_o(quota_s),
        .bs_valid(bs_valid), .bs_ready(bs_ready), .bs_data(bs_data),
        .bs_last(bs_last), .busy(busy)
    );

    quota_stream_gen #(.NCH(NCH), .BITSTREAM(BS), .QUANT(QN), .SPREAD(0)) u_dut_thermo (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_data(in_data), .in_unipol(in_unipol), .quota_o(quota_t),
        .bs_valid(bs_valid_t), .bs_ready(bs_ready), .bs_data(bs_data_t),
        .bs_last(bs_last_t), .busy(busy_t)
    );

    // Quota as a rounded fraction of the full input range times the stream length.
    function automatic int model_q(input int d, input bit uni);
        int u;
        if (uni) begin
            u = (d < 0) ? 0 : d;
            return (u * BS + (1 << (QN - 2))) / (1 << (QN - 1));
        end
        u = d + (1 << (QN - 1));
        return (u * BS + (1 << (QN - 1))) / (1 << QN);
    endfunction

    function automatic bit model_bit(input int q, input int t, input bit spread);
        if (spread) return (((t + 1) * q) / BS - (t * q) / BS) != 0;
        return t < q;
    endfunction

    task automatic send(input bit uni, input bit keep_valid);
        int n;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) in_data[c*QN +: QN] = din[c][QN-1:0];
        in_unipol = uni;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = keep_valid;
        for (int c = 0; c < NCH; c++) eq[c] = model_q(din[c], uni);
    endtask

    // Entered 1 time unit after the accepting clock edge.
    task automatic run_stream(input bit stalls);
        int  t, cyc, stall;
        int  ones_s [NCH];
        int  ones_t [NCH];
        bit  es, et;
        for (int c = 0; c < NCH; c++) begin
            ones_s[c] = 0;
            ones_t[c] = 0;
        end
        @(negedge clk);
        checks++;
        if (bs_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_cycle: valid=%b busy=%b ready=%b, want 0 1 0", bs_valid, busy, in_ready);
        end
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (quota_s[c*QW +: QW] !== QW'(eq[c]) || quota_t[c*QW +: QW] !== QW'(eq[c])) begin
                errors++;
                $display("FAIL quota ch%0d: got %0d/%0d, want %0d", c, quota_s[c*QW +: QW], quota_t[c*QW +: QW], eq[c]);
            end
        end
        t = 0;
        cyc = 0;
        stall = stalls ? int'($urandom_range(5)) : 0;
        while (t < BS && cyc < 300) begin
            checks++;
            if (bs_valid !== 1'b1 || bs_valid_t !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stream_flags beat %0d: valid=%b/%b ready=%b, want 1 1 0", t, bs_valid, bs_valid_t, in_ready);
            end
            for (int c = 0; c < NCH; c++) begin
                es = model_bit(eq[c], t, 1'b1);
                et = model_bit(eq[c], t, 1'b0);
                checks++;
                if (bs_data[c] !== es || bs_data_t[c] !== et) begin
                    errors++;
                    $display("FAIL bs_data ch%0d beat %0d: got %b/%b, want %b/%b", c, t, bs_data[c], bs_data_t[c], es, et);
                end
            end
            checks++;
            if (bs_last !== (t == BS - 1) || bs_last_t !== (t == BS - 1)) begin
                errors++;
                $display("FAIL bs_last beat %0d: got %b/%b, want %b", t, bs_last, bs_last_t, (t == BS - 1));
            end
            if (stall > 0) begin
                bs_ready = 1'b0;
                stall--;
            end else begin
                bs_ready = 1'b1;
                cap_sp[t] = bs_data[0];
                cap_th[t] = bs_data_t[0];
                for (int c = 0; c < NCH; c++) begin
                    ones_s[c] += int'(bs_data[c]);
                    ones_t[c] += int'(bs_data_t[c]);
                end
                t++;
                stall = stalls ? int'($urandom_range(5)) : 0;
            end
            @(negedge clk);
            cyc++;
        end
        bs_ready = 1'b0;
        checks++;
        if (t != BS) begin
            errors++;
            $display("FAIL stream_timeout: %0d beats, want %0d", t, BS);
        end
        checks++;
        if (bs_valid !== 1'b0 || bs_last !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            in_ready_t !== 1'b1 || busy_t !== 1'b0) begin
            errors++;
            $display("FAIL end_flags: valid=%b last=%b ready=%b busy=%b, want 0 0 1 0", bs_valid, bs_last, in_ready, busy);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (ones_s[c] != eq[c] || ones_t[c] != eq[c]) begin
                errors++;
                $display("FAIL ones ch%0d: got %0d/%0d, want %0d", c, ones_s[c], ones_t[c], eq[c]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || bs_valid !== 1'b0 || bs_last !== 1'b0 || busy !== 1'b0 ||
            bs_data !== '0 || quota_s !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b last=%b busy=%b data=%h quota=%h, want 1 0 0 0 0 0",
                     in_ready, bs_valid, bs_last, busy, bs_data, quota_s);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_bipolar();
        din = '{-128, 0, 127, -112};
        send(1'b0, 1'b0);
        run_stream(1'b0);
    endtask

    task automatic test_pattern();
        logic [BS-1:0] want_sp, want_th;
        want_sp = 8'b1010_0100;
        want_th = 8'b0000_0111;
        din = '{-40, -40, -40, -40};
        send(1'b0, 1'b0);
        run_stream(1'b0);
        checks++;
        if (cap_sp !== want_sp || cap_th !== want_th) begin
            errors++;
            $display("FAIL pattern_q3: got %b/%b, want %b/%b", cap_sp, cap_th, want_sp, want_th);
        end
    endtask

    task automatic test_unipolar();
        din = '{64, -5, 127, 0};
        send(1'b1, 1'b0);
        run_stream(1'b0);
    endtask

    task automatic test_random_stalls();
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < NCH; c++) din[c] = int'($urandom_range(255)) - 128;
            send(1'($urandom_range(1)), 1'b0);
            run_stream(1'b1);
        end
    endtask

    task automatic test_reset_mid();
        din = '{-40, 100, 20, -1};
        send(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bs_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bs_valid !== 1'b1 || bs_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_beat3: valid=%b last=%b, want 1 0", bs_valid, bs_last);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bs_valid !== 1'b0 || in_ready !== 1'b1 || quota_s !== '0 || bs_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: valid=%b ready=%b quota=%h last=%b busy=%b, want 0 1 0 0 0",
                     bs_valid, in_ready, quota_s, bs_last, busy);
        end
        bs_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bs_valid !== 1'b0 || bs_last !== 1'b0 || quota_s !== '0) begin
            errors++;
            $display("FAIL mid_hold: valid=%b last=%b quota=%h, want 0 0 0", bs_valid, bs_last, quota_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        din = '{5, -90, 64, 127};
        send(1'b1, 1'b0);
        run_stream(1'b0);
    endtask

    task automatic test_back_to_back();
        din = '{-128, 60, -12, 90};
        send(1'b0, 1'b1);
        din = '{127, -128, -40, 3};
        for (int c = 0; c < NCH; c++) in_data[c*QN +: QN] = din[c][QN-1:0];
        run_stream(1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < NCH; c++) eq[c] = model_q(din[c], 1'b0);
        run_stream(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bipolar();
        test_pattern();
        test_unipolar();
        test_random_stalls();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
